// File: rtl/fetch_unit.sv
// Program counter, instruction fetch sequencer (IDLE/REQ/WAIT) and instruction register.
// The FSM issues one req/ack transaction per ir_load and aborts on timeout or pc_rst.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              IW       = 32,
  parameter int              TIMEOUT  = 15,
  parameter logic [IW-1:0]   NOP_WORD = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            ir_load,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic [PC_W-1:0] pc_out,
  output logic [IW-1:0]   ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [15:0]     imm,
  output logic            ir_valid,
  output logic            fetch_busy,
  output logic            fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [PC_W-1:0] pc_abs;
  logic [PC_W-1:0] pc_off;

  // Branch immediate resized to the PC width: zero-extended for absolute, sign-extended for relative.
  generate
    if (PC_W <= 16) begin : g_narrow_pc
      assign pc_abs = imm[PC_W-1:0];
      assign pc_off = imm[PC_W-1:0];
    end else begin : g_wide_pc
      assign pc_abs = {{(PC_W-16){1'b0}}, imm};
      assign pc_off = {{(PC_W-16){imm[15]}}, imm};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= NOP_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: PC update
  always_comb begin
    pc_d = pc_q;
    if (pc_rst) begin
      pc_d = '0;
    end else if (pc_write) begin
      if (!pc_sel)     pc_d = pc_q + 1'b1;
      else if (br_sel) pc_d = pc_abs;
      else             pc_d = pc_q + pc_off;
    end
  end

  // Next-state: fetch sequencer
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (pc_rst) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Address is the PC before any concurrent pc_write takes effect.
        if (ir_load) begin
          addr_d  = pc_q;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (pc_rst) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (imem_ack) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = 8'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (pc_rst) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (imem_ack) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q >= 8'(TIMEOUT)) begin
          ir_d    = NOP_WORD;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req   = (state_q != S_IDLE);
    fetch_busy = (state_q != S_IDLE);
    imem_addr  = addr_q;
    pc_out     = pc_q;
    ir         = ir_q;
    ir_valid   = valid_q;
    fetch_err  = err_q;
    opcode     = ir_q[31:28];
    mm         = ir_q[27:24];
    rd         = ir_q[23:20];
    rs         = ir_q[19:16];
    rt         = ir_q[15:12];
    imm        = ir_q[15:0];
  end

endmodule
